// File: rtl/kb_lane_tracker.sv
// kb_lane_tracker: decodes a stream of PS/2 set-2 scan-code bytes (with F0
// break and E0 extended prefixes) into held state for four note lanes plus
// Enter. It produces one-cycle press/release pulses and queues lane events in a
// first-word fall-through FIFO.
//
// Optional feature macro: KB_EXT_ENTER_EN. When it is defined, keypad Enter
// (E0 5A / E0 F0 5A) drives lane 4 exactly like the main Enter key. When it is
// undefined, every E0-prefixed code is discarded.
//
// Event handshake: evt_valid is high whenever the FIFO holds an entry, and
// evt_data then shows the head entry as {is_press, lane[2:0]}. The head is
// consumed on a clock edge where evt_valid && evt_ready. evt_ready while empty
// is ignored. The producer side never waits: a push into a full FIFO without a
// simultaneous pop is dropped and sets the sticky evt_ovf flag.
module kb_lane_tracker #(
  parameter logic [7:0]  KEY0_CODE      = 8'h1C,
  parameter logic [7:0]  KEY1_CODE      = 8'h1B,
  parameter logic [7:0]  KEY2_CODE      = 8'h42,
  parameter logic [7:0]  KEY3_CODE      = 8'h4B,
  parameter logic [7:0]  ENTER_CODE     = 8'h5A,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_byte,
  input  logic       code_valid,
  output logic [4:0] held,
  output logic [4:0] press,
  output logic [4:0] release_o,
  output logic       evt_valid,
  output logic [3:0] evt_data,
  input  logic       evt_ready,
  output logic       evt_ovf,
  output logic [1:0] dbg_state
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    held_q, held_d;
  logic [4:0]    press_q, press_d;
  logic [4:0]    rel_q, rel_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic [3:0]    mem_q [FIFO_DEPTH];

  logic       is_make, is_break, is_ext, tmo_fire;
  logic [4:0] lane_oh;
  logic [2:0] lane_idx;
  logic       push_req, push_ok, pop, full;
  logic [3:0] push_data;

  // Prefix FSM next state, plus make/break classification of the current byte.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    tmo_fire = 1'b0;
    if (code_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (code_byte == 8'hF0)      state_d = S_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else                         is_make = 1'b1;
        end
        S_BRK: begin
          if (code_byte == 8'hF0)      state_d = S_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else begin
            is_break = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_EXT: begin
          if (code_byte == 8'hF0)      state_d = S_EXT_BRK;
          else if (code_byte == 8'hE0) state_d = S_EXT;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (code_byte == 8'hF0 || code_byte == 8'hE0) state_d = S_EXT_BRK;
          else begin
            is_break = 1'b1;
            is_ext   = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      // A prefix with no follow-up byte is abandoned; lane state is untouched.
      tmo_fire = 1'b1;
      state_d  = S_IDLE;
    end
  end

  // Timeout counter: counts only while a prefix is pending, restarts on every byte.
  always_comb begin
    tmo_d = '0;
    if (!code_valid && state_q != S_IDLE && !tmo_fire) tmo_d = tmo_q + 1'b1;
  end

  // Map the byte to a lane; extended codes only map when keypad Enter is enabled.
  always_comb begin
    lane_oh  = '0;
    lane_idx = '0;
    if (!is_ext) begin
      if (code_byte == KEY0_CODE)       begin lane_oh = 5'b00001; lane_idx = 3'd0; end
      else if (code_byte == KEY1_CODE)  begin lane_oh = 5'b00010; lane_idx = 3'd1; end
      else if (code_byte == KEY2_CODE)  begin lane_oh = 5'b00100; lane_idx = 3'd2; end
      else if (code_byte == KEY3_CODE)  begin lane_oh = 5'b01000; lane_idx = 3'd3; end
      else if (code_byte == ENTER_CODE) begin lane_oh = 5'b10000; lane_idx = 3'd4; end
    end
`ifdef KB_EXT_ENTER_EN
    else if (code_byte == ENTER_CODE) begin
      lane_oh  = 5'b10000;
      lane_idx = 3'd4;
    end
`endif
  end

  // Held-state update; repeats of held keys and breaks of idle keys are ignored.
  always_comb begin
    held_d    = held_q;
    press_d   = '0;
    rel_d     = '0;
    push_req  = 1'b0;
    push_data = '0;
    if (is_make && (lane_oh != '0) && ((lane_oh & held_q) == '0)) begin
      held_d    = held_q | lane_oh;
      press_d   = lane_oh;
      push_req  = 1'b1;
      push_data = {1'b1, lane_idx};
    end else if (is_break && ((lane_oh & held_q) != '0)) begin
      held_d    = held_q & ~lane_oh;
      rel_d     = lane_oh;
      push_req  = 1'b1;
      push_data = {1'b0, lane_idx};
    end
  end

  assign full    = (cnt_q == FULL_CNT);
  assign pop     = evt_ready && (cnt_q != '0);
  assign push_ok = push_req && (!full || pop);

  // State, lane and FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      held_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
      if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  // FIFO storage; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign held      = held_q;
  assign press     = press_q;
  assign release_o = rel_q;
  assign evt_valid = (cnt_q != '0);
  assign evt_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : 4'h0;
  assign evt_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kb_lane_tracker.sv
// Directed bench for kb_lane_tracker (short prefix timeout, 8-entry FIFO).
module tb_kb_lane_tracker;

  localparam int unsigned TMO = 16;

  logic       clk;
  logic       rst;
  logic [7:0] code_byte;
  logic       code_valid;
  logic [4:0] held, press, release_o;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_ready;
  logic       evt_ovf;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  kb_lane_tracker #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .code_byte(code_byte), .code_valid(code_valid),
    .held(held), .press(press), .release_o(release_o),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_ovf(evt_ovf), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one byte for one rising edge, return at the following negedge.
  task automatic send(input logic [7:0] b);
    code_byte  = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Driver: sample the head and pop it if present.
  task automatic pop_head(output logic v, output logic [3:0] d);
    v = evt_valid;
    d = evt_data;
    if (v) begin
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({held, press, release_o} !== 15'h0) begin
      n_fail++; $display("FAIL reset_lanes: got %h expected 0", {held, press, release_o});
    end
    n_checks++;
    if ({evt_valid, evt_data, evt_ovf, dbg_state} !== 8'h0) begin
      n_fail++; $display("FAIL reset_fifo: got %h expected 0", {evt_valid, evt_data, evt_ovf, dbg_state});
    end
  endtask

  task automatic test_make_break();
    logic v; logic [3:0] d, e;
    send(8'h1C);
    n_checks++;
    if (held !== 5'b00001 || press !== 5'b00001 || release_o !== 5'b0) begin
      n_fail++; $display("FAIL mb_make: got held=%b press=%b rel=%b expected 00001 00001 00000", held, press, release_o);
    end
    send(8'hF0);
    n_checks++;
    if (held !== 5'b00001 || press !== 5'b0 || dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL mb_prefix: got held=%b press=%b st=%0d expected 00001 00000 1", held, press, dbg_state);
    end
    send(8'h1C);
    n_checks++;
    if (held !== 5'b0 || release_o !== 5'b00001) begin
      n_fail++; $display("FAIL mb_break: got held=%b rel=%b expected 00000 00001", held, release_o);
    end
    @(negedge clk);
    n_checks++;
    if (release_o !== 5'b0) begin
      n_fail++; $display("FAIL mb_rel_pulse: got %b expected 00000", release_o);
    end
    exp_q.push_back(4'h8); exp_q.push_back(4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); pop_head(v, d); n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL mb_pop: got v=%b d=%h expected v=1 d=%h", v, d, e);
      end
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mb_empty: got %b expected 0", evt_valid); end
  endtask

  task automatic test_typematic();
    logic v; logic [3:0] d, e;
    for (int i = 0; i < 3; i++) begin
      send(8'h42);
      n_checks++;
      if (held !== 5'b00100 || press !== ((i == 0) ? 5'b00100 : 5'b0)) begin
        n_fail++; $display("FAIL tm_repeat%0d: got held=%b press=%b", i, held, press);
      end
    end
    send(8'hF0); send(8'h42);
    n_checks++;
    if (held !== 5'b0 || release_o !== 5'b00100) begin
      n_fail++; $display("FAIL tm_break: got held=%b rel=%b expected 00000 00100", held, release_o);
    end
    exp_q.push_back(4'hA); exp_q.push_back(4'h2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); pop_head(v, d); n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL tm_pop: got v=%b d=%h expected v=1 d=%h", v, d, e);
      end
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL tm_empty: got %b expected 0", evt_valid); end
  endtask

  task automatic test_ext_enter();
    logic v; logic [3:0] d, e;
    logic [4:0] exp_h;
`ifdef KB_EXT_ENTER_EN
    exp_h = 5'b10000;
    exp_q.push_back(4'hC); exp_q.push_back(4'h4);
`else
    exp_h = 5'b00000;
`endif
    send(8'hE0);
    n_checks++;
    if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL ext_state: got %0d expected 2", dbg_state); end
    send(8'h5A);
    n_checks++;
    if (held !== exp_h) begin n_fail++; $display("FAIL ext_make: got %b expected %b", held, exp_h); end
    send(8'hE0); send(8'h1C);
    n_checks++;
    if (held !== exp_h) begin n_fail++; $display("FAIL ext_other: got %b expected %b", held, exp_h); end
    send(8'hE0); send(8'hF0);
    n_checks++;
    if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL ext_brk_state: got %0d expected 3", dbg_state); end
    send(8'h5A);
    n_checks++;
    if (held !== 5'b0) begin n_fail++; $display("FAIL ext_break: got %b expected 00000", held); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); pop_head(v, d); n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL ext_pop: got v=%b d=%h expected v=1 d=%h", v, d, e);
      end
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ext_empty: got %b expected 0", evt_valid); end
  endtask

  task automatic test_full_push_pop();
    logic v; logic [3:0] d, e;
    logic [7:0] keys [4];
    keys[0] = 8'h1C; keys[1] = 8'h1B; keys[2] = 8'h42; keys[3] = 8'h4B;
    for (int i = 0; i < 4; i++) send(keys[i]);
    for (int i = 0; i < 4; i++) begin send(8'hF0); send(keys[i]); end
    evt_ready = 1'b1;
    send(8'h5A);
    evt_ready = 1'b0;
    n_checks++;
    if (evt_ovf !== 1'b0 || evt_valid !== 1'b1 || evt_data !== 4'h9 || held !== 5'b10000) begin
      n_fail++; $display("FAIL fpp_same_cycle: got ovf=%b v=%b d=%h held=%b expected 0 1 9 10000",
                         evt_ovf, evt_valid, evt_data, held);
    end
    exp_q = '{4'h9, 4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3, 4'hC};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); pop_head(v, d); n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL fpp_pop: got v=%b d=%h expected v=1 d=%h", v, d, e);
      end
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b expected 0", evt_valid); end
    send(8'hF0); send(8'h5A);
    pop_head(v, d); n_checks++;
    if (v !== 1'b1 || d !== 4'h4) begin n_fail++; $display("FAIL fpp_rel: got v=%b d=%h expected v=1 d=4", v, d); end
  endtask

  task automatic test_overflow();
    logic v; logic [3:0] d, e;
    logic [7:0] keys [4];
    keys[0] = 8'h1C; keys[1] = 8'h1B; keys[2] = 8'h42; keys[3] = 8'h4B;
    for (int i = 0; i < 4; i++) send(keys[i]);
    send(8'h5A);
    for (int i = 0; i < 4; i++) begin send(8'hF0); send(keys[i]); end
    n_checks++;
    if (evt_ovf !== 1'b1 || held !== 5'b10000) begin
      n_fail++; $display("FAIL ovf_flag: got ovf=%b held=%b expected 1 10000", evt_ovf, held);
    end
    exp_q = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'h1, 4'h2};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); pop_head(v, d); n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL ovf_pop: got v=%b d=%h expected v=1 d=%h", v, d, e);
      end
    end
    n_checks++;
    if (evt_valid !== 1'b0 || evt_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after: got v=%b ovf=%b expected 0 1", evt_valid, evt_ovf);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h1B);
    send(8'hF0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (held !== 5'b0 || evt_valid !== 1'b0 || evt_ovf !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_clear: got held=%b v=%b ovf=%b st=%0d expected 0 0 0 0",
                         held, evt_valid, evt_ovf, dbg_state);
    end
    send(8'h1C);
    n_checks++;
    if (held !== 5'b00001 || evt_data !== 4'h8) begin
      n_fail++; $display("FAIL rstmid_make: got held=%b d=%h expected 00001 8", held, evt_data);
    end
    evt_ready = 1'b1; @(negedge clk); evt_ready = 1'b0;
    send(8'hF0); send(8'h1C);
    evt_ready = 1'b1; @(negedge clk); evt_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic v; logic [3:0] d, e;
    send(8'hF0);
    idle(TMO);
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL tmo_idle: got %0d expected 0", dbg_state); end
    send(8'h1B);
    n_checks++;
    if (held !== 5'b00010 || press !== 5'b00010) begin
      n_fail++; $display("FAIL tmo_make: got held=%b press=%b expected 00010 00010", held, press);
    end
    send(8'hF0);
    idle(TMO - 3);
    n_checks++;
    if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL tmo_pending: got %0d expected 1", dbg_state); end
    send(8'h1B);
    n_checks++;
    if (held !== 5'b0 || release_o !== 5'b00010) begin
      n_fail++; $display("FAIL tmo_break: got held=%b rel=%b expected 00000 00010", held, release_o);
    end
    exp_q.push_back(4'h9); exp_q.push_back(4'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); pop_head(v, d); n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL tmo_pop: got v=%b d=%h expected v=1 d=%h", v, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(8'h1B); send(8'h4B); send(8'hF0); send(8'h1B); send(8'h1C);
    n_checks++;
    if (held !== 5'b01001 || press !== 5'b00001) begin
      n_fail++; $display("FAIL b2b_held: got held=%b press=%b expected 01001 00001", held, press);
    end
  endtask

  initial begin
    rst        = 1'b0;
    code_byte  = 8'h00;
    code_valid = 1'b0;
    evt_ready  = 1'b0;
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_typematic();
    test_ext_enter();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
